// File: rtl/aurora_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aurora_pkg
//  Purpose  : Shared TX-lane types and constants: ordered-set codes from
//             data_controller, 64B/66B block-type fields, sync headers and
//             scrambler width.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package aurora_pkg;

    localparam int AXI_DATA_SIZE = 64;

    // Ordered-set request coming from data_controller
    typedef enum logic [1:0] {
        NONE = 2'd0,
        SCP  = 2'd1,
        I    = 2'd2,
        ECP  = 2'd3
    } ordered_sets_e;

    // Block-type fields carried in the low byte of a control block
    localparam logic [7:0] BTF_IDLE = 8'h78;
    localparam logic [7:0] BTF_CC   = 8'h80;
    localparam logic [7:0] BTF_SCP  = 8'h1E;
    localparam logic [7:0] BTF_ECP  = 8'hE1;

    // 64B/66B sync headers
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Scrambler polynomial x^58 + x^39 + 1
    localparam int SCR_WIDTH = 58;

    // Frame tracking state of the encoder
    typedef enum logic {
        OUT_FRAME = 1'b0,
        IN_FRAME  = 1'b1
    } frame_state_e;

    // Control-block payload before scrambling: BTF in the low byte, rest zero
    function automatic logic [AXI_DATA_SIZE-1:0] ctrl_payload(input logic [7:0] btf);
        return {56'h0, btf};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_scrambler.sv
`default_nettype none
// ============================================================================
//  Module   : tx_scrambler
//  Purpose  : Self-synchronous x^58+x^39+1 scrambler for one 64-bit payload
//             per clock. Combinational 64-bit unroll of the serial scrambler,
//             processing bit 0 first, with a registered 58-bit state.
//  Ports    : clk       in   clock, posedge
//             rst_n     in   synchronous active-low reset (loads seed)
//             seed      in   SCR_WIDTH  state loaded on reset
//             data_in   in   64         plain payload of the current block
//             data_out  out  64         scrambled payload (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module tx_scrambler
    import aurora_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SCR_WIDTH-1:0]     seed,
    input  logic [AXI_DATA_SIZE-1:0] data_in,
    output logic [AXI_DATA_SIZE-1:0] data_out
);

    logic [SCR_WIDTH-1:0] scr_state;
    logic [SCR_WIDTH-1:0] scr_next;
    logic [SCR_WIDTH-1:0] work;
    logic                 bit_out;

    // Each scrambled bit is shifted back into the state before the next bit
    // is processed, so the loop carries the state through all 64 bits.
    always_comb begin
        work     = scr_state;
        bit_out  = 1'b0;
        data_out = '0;
        for (int k = 0; k < AXI_DATA_SIZE; k++) begin
            bit_out     = data_in[k] ^ work[38] ^ work[57];
            data_out[k] = bit_out;
            work        = {work[SCR_WIDTH-2:0], bit_out};
        end
        scr_next = work;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scr_state <= seed;
        end else begin
            scr_state <= scr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_block_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tx_block_encoder
//  Purpose  : Builds one 64B/66B block per clock from the ordered-set request
//             and data word of data_controller. Tracks framing, inserts
//             clock-compensation blocks into idle slots and flags framing
//             violations. One clock of latency, no handshake.
//  Ports    : clk           in   clock, posedge
//             rst_n         in   synchronous active-low reset
//             ordered_sets  in   ordered_sets_e  NONE/SCP/I/ECP request
//             data_in       in   64   payload, used only for data blocks
//             tx_header     out  2    sync header (01 data, 10 control)
//             tx_data       out  64   scrambled payload
//             cc_sent       out  1    pulse: current block is CC
//             frame_err     out  1    pulse: framing violation
//  Revision : 1.0  initial release
// ============================================================================
module tx_block_encoder
    import aurora_pkg::*;
#(
    parameter int                   CC_PERIOD = 5000,
    parameter logic [SCR_WIDTH-1:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  ordered_sets_e            ordered_sets,
    input  logic [AXI_DATA_SIZE-1:0] data_in,
    output logic [1:0]               tx_header,
    output logic [AXI_DATA_SIZE-1:0] tx_data,
    output logic                     cc_sent,
    output logic                     frame_err
);

    localparam int                CNT_W   = $clog2(CC_PERIOD);
    localparam logic [CNT_W-1:0]  CC_LAST = CNT_W'(CC_PERIOD - 1);

    frame_state_e               state;
    frame_state_e               state_next;
    logic [CNT_W-1:0]           cc_cnt;
    logic                       cc_pending;
    logic                       cc_pending_next;
    logic                       cc_wrap;
    logic                       cc_avail;
    logic                       idle_slot;
    logic                       cc_fire;
    logic                       err_next;
    logic [1:0]                 hdr_next;
    logic [AXI_DATA_SIZE-1:0]   payload;
    logic [AXI_DATA_SIZE-1:0]   payload_scr;

    // A wrap in this very cycle can already be served by an idle slot.
    assign cc_wrap  = (cc_cnt == CC_LAST);
    assign cc_avail = cc_pending | cc_wrap;

    always_comb begin
        state_next = state;
        hdr_next   = SYNC_CTRL;
        payload    = ctrl_payload(BTF_IDLE);
        idle_slot  = 1'b0;
        err_next   = 1'b0;
        case (ordered_sets)
            SCP: begin
                payload    = ctrl_payload(BTF_SCP);
                err_next   = (state == IN_FRAME);
                state_next = IN_FRAME;
            end
            ECP: begin
                if (state == IN_FRAME) begin
                    payload    = ctrl_payload(BTF_ECP);
                    state_next = OUT_FRAME;
                end else begin
                    // Stray ECP degrades to an idle slot so CC can still go out
                    idle_slot = 1'b1;
                    err_next  = 1'b1;
                end
            end
            I: begin
                idle_slot = 1'b1;
            end
            default: begin
                if (state == IN_FRAME) begin
                    hdr_next = SYNC_DATA;
                    payload  = data_in;
                end else begin
                    idle_slot = 1'b1;
                end
            end
        endcase

        cc_fire = idle_slot & cc_avail;
        if (cc_fire) begin
            payload = ctrl_payload(BTF_CC);
        end
        // Pending requests collapse into one; only an idle slot clears it.
        cc_pending_next = cc_fire ? 1'b0 : cc_avail;
    end

    tx_scrambler u_scrambler (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed     (SCR_SEED),
        .data_in  (payload),
        .data_out (payload_scr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= OUT_FRAME;
            cc_cnt     <= '0;
            cc_pending <= 1'b0;
            tx_header  <= SYNC_CTRL;
            tx_data    <= '0;
            cc_sent    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cc_cnt     <= cc_wrap ? '0 : cc_cnt + 1'b1;
            cc_pending <= cc_pending_next;
            tx_header  <= hdr_next;
            tx_data    <= payload_scr;
            cc_sent    <= cc_fire;
            frame_err  <= err_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_block_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_block_encoder
//  Purpose  : Self-checking bench for tx_block_encoder with CC_PERIOD=8.
//             A reference model pushes expected blocks to a scoreboard as
//             stimulus is driven; outputs are popped and compared one clock
//             later, and a reference descrambler recovers the payloads.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_block_encoder;
    import aurora_pkg::*;

    localparam int             CC_P = 8;
    localparam logic [57:0]    SEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic                      clk;
    logic                      rst_n;
    ordered_sets_e             ordered_sets;
    logic [63:0]               data_in;
    logic [1:0]                tx_header;
    logic [63:0]               tx_data;
    logic                      cc_sent;
    logic                      frame_err;

    tx_block_encoder #(.CC_PERIOD(CC_P), .SCR_SEED(SEED)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ordered_sets (ordered_sets),
        .data_in      (data_in),
        .tx_header    (tx_header),
        .tx_data      (tx_data),
        .cc_sent      (cc_sent),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] data;
        logic [63:0] plain;
        logic        cc;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    // reference model state
    logic        m_frame;
    int          m_cnt;
    logic        m_pend;
    logic [57:0] m_scr;
    // reference descrambler state
    logic [57:0] d_scr;

    // last observed block
    logic [1:0]  last_hdr;
    logic [63:0] last_plain;
    logic        last_cc;
    logic        last_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_push(input ordered_sets_e os, input logic [63:0] d, input logic r);
        exp_t        e;
        logic        wrap;
        logic        avail;
        logic        idle;
        logic [63:0] p;
        logic [57:0] s;
        logic        b;
        e.hdr = SYNC_CTRL; e.data = '0; e.plain = '0; e.cc = 1'b0; e.err = 1'b0;
        if (!r) begin
            m_frame = 1'b0; m_cnt = 0; m_pend = 1'b0; m_scr = SEED;
        end else begin
            wrap  = (m_cnt == CC_P - 1);
            avail = m_pend | wrap;
            idle  = 1'b0;
            p     = {56'h0, BTF_IDLE};
            case (os)
                SCP: begin p = {56'h0, BTF_SCP}; e.err = m_frame; m_frame = 1'b1; end
                ECP: begin
                    if (m_frame) begin p = {56'h0, BTF_ECP}; m_frame = 1'b0; end
                    else begin idle = 1'b1; e.err = 1'b1; end
                end
                I: idle = 1'b1;
                default: begin
                    if (m_frame) begin e.hdr = SYNC_DATA; p = d; end
                    else idle = 1'b1;
                end
            endcase
            if (idle && avail) begin p = {56'h0, BTF_CC}; e.cc = 1'b1; m_pend = 1'b0; end
            else m_pend = avail;
            m_cnt = wrap ? 0 : m_cnt + 1;
            s = m_scr;
            for (int k = 0; k < 64; k++) begin
                b = p[k] ^ s[38] ^ s[57];
                e.data[k] = b;
                s = {s[56:0], b};
            end
            m_scr   = s;
            e.plain = p;
        end
        sb.push_back(e);
    endtask

    // Drive one cycle (called at negedge), then compare the resulting block.
    task automatic step(input ordered_sets_e os, input logic [63:0] d, input logic r);
        exp_t        e;
        logic [57:0] s;
        logic [63:0] p;
        ordered_sets = os;
        data_in      = d;
        rst_n        = r;
        model_push(os, d, r);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        p = '0;
        if (!r) begin
            d_scr = SEED;
        end else begin
            s = d_scr;
            for (int k = 0; k < 64; k++) begin
                p[k] = tx_data[k] ^ s[38] ^ s[57];
                s = {s[56:0], tx_data[k]};
            end
            d_scr = s;
        end
        last_hdr = tx_header; last_plain = p; last_cc = cc_sent; last_err = frame_err;
        check("hdr", {62'h0, tx_header}, {62'h0, e.hdr});
        check("data", tx_data, e.data);
        check("cc_sent", {63'h0, cc_sent}, {63'h0, e.cc});
        check("frame_err", {63'h0, frame_err}, {63'h0, e.err});
        if (r) check("descr", p, e.plain);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncc;
        int ndata;
        int ncc_in;
        logic [63:0] w;
        rst_n = 1'b0; ordered_sets = NONE; data_in = '0; d_scr = SEED;
        m_frame = 1'b0; m_cnt = 0; m_pend = 1'b0; m_scr = SEED;
        @(negedge clk);
        step(NONE, 64'h0, 1'b0);
        step(NONE, 64'h0, 1'b0);

        // Idle stream: first block IDLE, CC on blocks 8 and 16
        ncc = 0;
        for (int i = 0; i < 17; i++) begin
            step(NONE, 64'h0, 1'b1);
            if (i == 0) begin
                check("first_hdr", {62'h0, last_hdr}, {62'h0, SYNC_CTRL});
                check("first_btf", last_plain, 64'h78);
            end
            if (i == 7 || i == 15) check("cc_slot", {63'h0, last_cc}, 64'h1);
            ncc += int'(last_cc);
        end
        check("cc_count", 64'(ncc), 64'd2);

        // Short frame
        step(SCP, 64'h0, 1'b1);
        check("scp_btf", last_plain, 64'h1E);
        for (int i = 1; i <= 3; i++) begin
            w = {16{4'(i)}};
            step(NONE, w, 1'b1);
            check("frm_hdr", {62'h0, last_hdr}, {62'h0, SYNC_DATA});
            check("frm_word", last_plain, w);
        end
        step(ECP, 64'h0, 1'b1);
        check("ecp_btf", last_plain, 64'hE1);
        check("ecp_err", {63'h0, last_err}, 64'h0);

        // Long frame across a CC wrap
        ndata = 0; ncc_in = 0;
        step(SCP, 64'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(NONE, {$urandom, $urandom}, 1'b1);
            ndata += int'(last_hdr == SYNC_DATA);
            ncc_in += int'(last_cc);
        end
        step(ECP, 64'h0, 1'b1);
        check("long_data_cnt", 64'(ndata), 64'd20);
        check("long_cc_in", 64'(ncc_in), 64'd0);
        step(NONE, 64'h0, 1'b1);
        check("cc_after_ecp", {63'h0, last_cc}, 64'h1);
        check("cc_after_btf", last_plain, 64'h80);

        // Idle request inside a frame
        step(SCP, 64'h0, 1'b1);
        step(NONE, 64'hA5A5_0000_FFFF_1234, 1'b1);
        step(I, 64'hDEAD_BEEF_0000_0001, 1'b1);
        check("i_slot_hdr", {62'h0, last_hdr}, {62'h0, SYNC_CTRL});
        check("i_slot_btf", 64'(last_plain == 64'h78 || last_plain == 64'h80), 64'd1);
        step(NONE, 64'h0123_4567_89AB_CDEF, 1'b1);
        check("after_i_hdr", {62'h0, last_hdr}, {62'h0, SYNC_DATA});
        check("after_i_word", last_plain, 64'h0123_4567_89AB_CDEF);
        step(ECP, 64'h0, 1'b1);

        // Framing violations
        step(ECP, 64'h0, 1'b1);
        check("stray_ecp_err", {63'h0, last_err}, 64'h1);
        check("stray_ecp_hdr", {62'h0, last_hdr}, {62'h0, SYNC_CTRL});
        step(SCP, 64'h0, 1'b1);
        step(SCP, 64'h0, 1'b1);
        check("dbl_scp_err", {63'h0, last_err}, 64'h1);
        check("dbl_scp_btf", last_plain, 64'h1E);
        step(ECP, 64'h0, 1'b1);

        // Reset in the middle of a frame
        step(SCP, 64'h0, 1'b1);
        step(NONE, 64'h5555_6666_7777_8888, 1'b1);
        step(NONE, 64'h9999_0000_1111_2222, 1'b0);
        step(NONE, 64'h3333_4444_5555_6666, 1'b1);
        check("rst_mid_hdr", {62'h0, last_hdr}, {62'h0, SYNC_CTRL});
        check("rst_mid_btf", last_plain, 64'h78);
        check("rst_mid_err", {63'h0, last_err}, 64'h0);

        // Random mix
        for (int i = 0; i < 150; i++) begin
            step(ordered_sets_e'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
